branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Controls branch resolution in the ID stage of the pipelined MIPS-Lite CPU.
- Decodes BEQ/BNE in ID and drives op and operand-forwarding selects to the branch comparator (RN1/RN2/OP -> zero).
- Stalls the front end while comparator operands are still in flight.
- On a taken branch, redirects the PC and flushes IF/ID.

Parameters:
- OP_BEQ, 6'd4, opcode of branch-if-equal.
- OP_BNE, 6'd5, opcode of branch-if-not-equal.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_op  in  6  opcode in ID.
- id_rs  in  REG_AW  rs address in ID.
- id_rt  in  REG_AW  rt address in ID.
- ex_regwrite  in  1  EX instruction writes a register.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  REG_AW  EX destination register.
- mem_regwrite  in  1  MEM instruction writes a register.
- mem_memread  in  1  MEM instruction is a load.
- mem_rd  in  REG_AW  MEM destination register.
- cmp_zero  in  1  comparator result; 1 = branch condition true.
- cmp_op  out  6  opcode to comparator.
- fwd_a  out  1  RN1 source: 0 = register file, 1 = MEM-stage ALU result.
- fwd_b  out  1  RN2 source, same encoding as fwd_a.
- stall  out  1  freeze PC and IF/ID; bubble into EX.
- pc_src  out  1  1 = load branch target into PC.
- flush_ifid  out  1  squash the IF/ID register.

Behaviour:
- is_br = id_valid & (id_op==OP_BEQ | id_op==OP_BNE).
- For a non-branch, cmp_op = 6'd0.
- Register 0 never matches for any hazard or forwarding check.
- Match definitions (X in {rs, rt}):
  - exm(X) = ex_regwrite & ex_rd==X & X!=0
  - memm(X) = mem_regwrite & mem_rd==X & X!=0
- Stall depth D, computed only when is_br:
  - D = 2 if any exm with ex_memread.
  - else D = 1 if any exm (ALU result not yet available), or any memm with mem_memread.
  - else D = 0.
  - An EX match takes precedence over a MEM match on the same register.
- Forwarding (combinational):
  - fwd_a = is_br & memm(rs) & ~mem_memread & ~exm(rs).
  - fwd_b is the same with rt.
- FSM states: IDLE, STALL2, RESOLVE_WAIT. State is a registered 2-bit encoding.
- IDLE:
  - is_br & D!=0: stall=1 combinationally in the same cycle. Next state STALL2 if D==2, else RESOLVE_WAIT.
  - is_br & D==0: resolve this cycle. pc_src = flush_ifid = cmp_zero. Stay in IDLE.
  - Otherwise all control outputs are 0.
- STALL2: stall=1; next state RESOLVE_WAIT.
- RESOLVE_WAIT:
  - stall=0. Re-evaluate D with the current pipeline inputs.
  - D==0: resolve (pc_src = flush_ifid = cmp_zero); next state IDLE.
  - D!=0: stall=1 and follow the IDLE transition rules.
  - If is_br drops (ID invalidated), return to IDLE with no outputs.
- Outputs:
  - pc_src, flush_ifid and stall are Mealy, valid in the same cycle as their inputs.
  - pc_src and flush_ifid are one-cycle pulses per resolved branch.
- Resolution latency:
  - D=0: 0 cycles.
  - D=1: 1 stall cycle.
  - D=2: 2 stall cycles.
- Reset:
  - state = IDLE and all outputs 0 during and after rst.
  - rst mid-stall aborts the sequence; no pc_src pulse is emitted.
- Opcodes other than BEQ/BNE (e.g. 6'd6) are not branches: no stall, no redirect.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_taken[15:0], stat_nottaken[15:0], stat_stalls[15:0].
  - All are saturating counters, cleared by rst.
  - stat_taken / stat_nottaken increment once per resolved branch.
  - stat_stalls increments once per stall-asserted cycle.
  - Each counter holds at 16'hFFFF.
- Undefined: ports and counters are absent; core behaviour is identical.

Test Plan:
- BNE, rs=2, rt=3, no hazards, cmp_zero=1 -> same cycle: cmp_op=5, pc_src=1, flush_ifid=1, stall=0. Next cycle pulses are 0.
- BEQ, rs=1, rt=2, cmp_zero=0 -> pc_src=0, flush_ifid=0, no stall.
- BEQ rs=5; EX is a load with ex_rd=5 -> stall=1 for exactly 2 cycles. Third cycle: MEM forwarding not used for the load (D re-evaluated to 0 once the load reaches WB). pc_src follows cmp_zero.
- BEQ rt=7; mem_regwrite=1, mem_rd=7, mem_memread=0 -> fwd_b=1, fwd_a=0, stall=0. With rt=0 and mem_rd=0 -> fwd_b=0.
- rst asserted in STALL2 -> next cycle state IDLE, stall=0; no pc_src pulse follows.
- OP=6'd6 with any operands -> stall=0, pc_src=0. With BRANCH_STATS_EN: counters unchanged; 3 taken branches -> stat_taken=3.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch resolution for the MIPS-Lite pipeline.
// Decodes BEQ/BNE, selects comparator operand forwarding, stalls while the
// comparator operands are still in flight, and redirects/flushes on a taken branch.
// Optional macro BRANCH_STATS_EN adds saturating taken/not-taken/stall counters.
module branch_resolve_ctrl #(
  parameter logic [5:0]  OP_BEQ = 6'd4,
  parameter logic [5:0]  OP_BNE = 6'd5,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              cmp_zero,
  output logic [5:0]        cmp_op,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              stall,
  output logic              pc_src,
  output logic              flush_ifid
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       stat_taken,
  output logic [15:0]       stat_nottaken,
  output logic [15:0]       stat_stalls
`endif
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    STALL2       = 2'd1,
    RESOLVE_WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_is_br;
  logic        w_exm_a, w_exm_b, w_memm_a, w_memm_b;
  logic [1:0]  w_depth;
  logic        w_stall;
  logic        w_resolve;

  // Branch decode and hazard matching; register 0 never matches.
  always_comb begin
    w_is_br  = id_valid && ((id_op == OP_BEQ) || (id_op == OP_BNE));
    w_exm_a  = ex_regwrite  && (ex_rd  == id_rs) && (id_rs != '0);
    w_exm_b  = ex_regwrite  && (ex_rd  == id_rt) && (id_rt != '0);
    w_memm_a = mem_regwrite && (mem_rd == id_rs) && (id_rs != '0);
    w_memm_b = mem_regwrite && (mem_rd == id_rt) && (id_rt != '0);
    w_depth  = 2'd0;
    if (w_is_br) begin
      if ((w_exm_a || w_exm_b) && ex_memread)
        w_depth = 2'd2;
      else if (w_exm_a || w_exm_b || ((w_memm_a || w_memm_b) && mem_memread))
        w_depth = 2'd1;
    end
  end

  // Next-state and stall/resolve decision.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      IDLE, RESOLVE_WAIT: begin
        if (!w_is_br) begin
          w_state_nxt = IDLE;
        end else if (w_depth == 2'd0) begin
          w_resolve   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_stall     = 1'b1;
          w_state_nxt = (w_depth == 2'd2) ? STALL2 : RESOLVE_WAIT;
        end
      end
      STALL2: begin
        w_stall     = 1'b1;
        w_state_nxt = RESOLVE_WAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Mealy outputs, forced low while reset is asserted.
  always_comb begin
    cmp_op     = (w_is_br && !rst) ? id_op : 6'd0;
    fwd_a      = !rst && w_is_br && w_memm_a && !mem_memread && !w_exm_a;
    fwd_b      = !rst && w_is_br && w_memm_b && !mem_memread && !w_exm_b;
    stall      = w_stall && !rst;
    pc_src     = w_resolve && cmp_zero && !rst;
    flush_ifid = w_resolve && cmp_zero && !rst;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken, r_nottaken, r_stalls;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating branch/stall statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken    <= '0;
      r_nottaken <= '0;
      r_stalls   <= '0;
    end else begin
      if (w_resolve && cmp_zero && (r_taken != CNT_MAX))
        r_taken <= r_taken + CNT_W'(1);
      if (w_resolve && !cmp_zero && (r_nottaken != CNT_MAX))
        r_nottaken <= r_nottaken + CNT_W'(1);
      if (w_stall && (r_stalls != CNT_MAX))
        r_stalls <= r_stalls + CNT_W'(1);
    end
  end

  assign stat_taken    = r_taken;
  assign stat_nottaken = r_nottaken;
  assign stat_stalls   = r_stalls;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed vectors with literal expectations,
// plus a stall-countdown reference model compared on every negative edge.
module tb_branch_resolve_ctrl;

  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [5:0]        id_op;
  logic [REG_AW-1:0] id_rs, id_rt;
  logic              ex_regwrite, ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_regwrite, mem_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              cmp_zero;
  logic [5:0]        cmp_op;
  logic              fwd_a, fwd_b, stall, pc_src, flush_ifid;
`ifdef BRANCH_STATS_EN
  logic [15:0]       stat_taken, stat_nottaken, stat_stalls;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
    .cmp_zero(cmp_zero), .cmp_op(cmp_op), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall(stall), .pc_src(pc_src), .flush_ifid(flush_ifid)
`ifdef BRANCH_STATS_EN
    , .stat_taken(stat_taken), .stat_nottaken(stat_nottaken), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Unconditional stall cycles still owed before the branch is re-examined.
  int m_hold = 0, m_hold_nxt = 0;
  int m_taken = 0, m_nottaken = 0, m_stalls = 0;
  int m_taken_nxt = 0, m_nottaken_nxt = 0, m_stalls_nxt = 0;
  bit m_live = 0;

  function automatic bit match(input bit we, input int rd, input int x);
    return we && (rd == x) && (x != 0);
  endfunction

  always @(negedge clk) begin
    bit br, ea, eb, ma, mb;
    int d, e_op, e_fa, e_fb, e_st, e_pc;
    br = id_valid && (id_op == 6'd4 || id_op == 6'd5);
    ea = match(ex_regwrite, ex_rd, id_rs);
    eb = match(ex_regwrite, ex_rd, id_rt);
    ma = match(mem_regwrite, mem_rd, id_rs);
    mb = match(mem_regwrite, mem_rd, id_rt);
    if ((ea || eb) && ex_memread) d = 2;
    else if (ea || eb || ((ma || mb) && mem_memread)) d = 1;
    else d = 0;
    e_op = 0; e_fa = 0; e_fb = 0; e_st = 0; e_pc = 0;
    m_hold_nxt = 0;
    if (!rst) begin
      e_op = br ? int'(id_op) : 0;
      e_fa = int'(br && ma && !mem_memread && !ea);
      e_fb = int'(br && mb && !mem_memread && !eb);
      if (m_hold > 0) begin
        e_st = 1;
        m_hold_nxt = m_hold - 1;
      end else if (br) begin
        if (d == 0) e_pc = int'(cmp_zero);
        else begin
          e_st = 1;
          m_hold_nxt = d - 1;
        end
      end
    end
    m_taken_nxt    = rst ? 0 : m_taken    + ((e_pc == 1 && m_taken < 65535) ? 1 : 0);
    m_nottaken_nxt = rst ? 0 : m_nottaken +
                     ((br && m_hold == 0 && d == 0 && !cmp_zero && m_nottaken < 65535) ? 1 : 0);
    m_stalls_nxt   = rst ? 0 : m_stalls   + ((e_st == 1 && m_stalls < 65535) ? 1 : 0);
    if (m_live) begin
      chk("m_cmp_op", int'(cmp_op), e_op);
      chk("m_fwd_a", int'(fwd_a), e_fa);
      chk("m_fwd_b", int'(fwd_b), e_fb);
      chk("m_stall", int'(stall), e_st);
      chk("m_pc_src", int'(pc_src), e_pc);
      chk("m_flush", int'(flush_ifid), e_pc);
`ifdef BRANCH_STATS_EN
      chk("m_stat_taken", int'(stat_taken), m_taken);
      chk("m_stat_nottaken", int'(stat_nottaken), m_nottaken);
      chk("m_stat_stalls", int'(stat_stalls), m_stalls);
`endif
    end
  end

  always @(posedge clk) begin
    if (rst) m_live <= 1'b1;
    m_hold     <= m_hold_nxt;
    m_taken    <= m_taken_nxt;
    m_nottaken <= m_nottaken_nxt;
    m_stalls   <= m_stalls_nxt;
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs just after the rising edge, settle before checks.
  task automatic apply(input bit r, input bit v, input int op, input int rs, input int rt,
                       input bit exw, input bit exl, input int exd,
                       input bit mw, input bit ml, input int md, input bit cz);
    @(posedge clk); #1;
    rst = r; id_valid = v; id_op = 6'(op); id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
    ex_regwrite = exw; ex_memread = exl; ex_rd = REG_AW'(exd);
    mem_regwrite = mw; mem_memread = ml; mem_rd = REG_AW'(md);
    cmp_zero = cz;
    #2;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = '0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_rd = '0; cmp_zero = 1'b0;

    // Reset with a resolvable branch present: outputs held low.
    apply(1, 1, 5, 2, 3, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_stall", int'(stall), 0);
    chk("rst_pc_src", int'(pc_src), 0);
    chk("rst_cmp_op", int'(cmp_op), 0);

    // BNE, no hazards, taken: same-cycle redirect.
    apply(0, 1, 5, 2, 3, 0, 0, 0, 0, 0, 0, 1);
    chk("bne_cmp_op", int'(cmp_op), 5);
    chk("bne_pc_src", int'(pc_src), 1);
    chk("bne_flush", int'(flush_ifid), 1);
    chk("bne_stall", int'(stall), 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("bne_pulse_end", int'(pc_src), 0);

    // BEQ not taken.
    apply(0, 1, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_nt_pc_src", int'(pc_src), 0);
    chk("beq_nt_stall", int'(stall), 0);

    // BEQ behind a load in EX: two stall cycles, then resolve.
    apply(0, 1, 4, 5, 0, 1, 1, 5, 0, 0, 0, 1);
    chk("ld_stall1", int'(stall), 1);
    chk("ld_pc1", int'(pc_src), 0);
    apply(0, 1, 4, 5, 0, 0, 0, 0, 1, 1, 5, 1);
    chk("ld_stall2", int'(stall), 1);
    chk("ld_pc2", int'(pc_src), 0);
    apply(0, 1, 4, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("ld_stall3", int'(stall), 0);
    chk("ld_fwd_a3", int'(fwd_a), 0);
    chk("ld_pc3", int'(pc_src), 1);

    // MEM ALU result forwarded to RN2; register 0 never forwards.
    apply(0, 1, 4, 1, 7, 0, 0, 0, 1, 0, 7, 0);
    chk("fwdb_b", int'(fwd_b), 1);
    chk("fwdb_a", int'(fwd_a), 0);
    chk("fwdb_stall", int'(stall), 0);
    apply(0, 1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("fwd_r0", int'(fwd_b), 0);

    // EX ALU producer: one stall, then forward from MEM and resolve.
    apply(0, 1, 5, 4, 0, 1, 0, 4, 0, 0, 0, 1);
    chk("alu_stall1", int'(stall), 1);
    apply(0, 1, 5, 4, 0, 0, 0, 0, 1, 0, 4, 1);
    chk("alu_stall2", int'(stall), 0);
    chk("alu_fwd_a", int'(fwd_a), 1);
    chk("alu_pc", int'(pc_src), 1);

    // EX match hides a MEM match on the same register (no MEM forward).
    apply(0, 1, 4, 3, 0, 1, 0, 3, 1, 0, 3, 0);
    chk("prec_fwd_a", int'(fwd_a), 0);
    chk("prec_stall", int'(stall), 1);
    apply(0, 1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("prec_resolve_stall", int'(stall), 0);

    // Load in MEM: one stall; ID then invalidated returns quietly.
    apply(0, 1, 4, 6, 0, 0, 0, 0, 1, 1, 6, 1);
    chk("mld_stall", int'(stall), 1);
    chk("mld_fwd_a", int'(fwd_a), 0);
    apply(0, 0, 4, 6, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mld_drop_pc", int'(pc_src), 0);
    chk("mld_drop_stall", int'(stall), 0);

    // Reset while in STALL2 aborts the branch.
    apply(0, 1, 4, 9, 0, 1, 1, 9, 0, 0, 0, 1);
    chk("rs2_stall", int'(stall), 1);
    apply(1, 1, 4, 9, 0, 0, 0, 0, 1, 1, 9, 1);
    chk("rs2_rst_stall", int'(stall), 0);
    chk("rs2_rst_pc", int'(pc_src), 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rs2_after_stall", int'(stall), 0);
    chk("rs2_after_pc", int'(pc_src), 0);

    // Register 0 hazards are ignored.
    apply(0, 1, 4, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    chk("r0_stall", int'(stall), 0);
    chk("r0_pc", int'(pc_src), 1);

    // Opcode 6 is not a branch even with a load hazard.
    apply(0, 1, 6, 8, 8, 1, 1, 8, 0, 0, 0, 1);
    chk("op6_stall", int'(stall), 0);
    chk("op6_pc", int'(pc_src), 0);
    chk("op6_cmp_op", int'(cmp_op), 0);

    // Three taken branches after a reset.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 4, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 1, 5, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 1, 4, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    apply(0, 1, 6, 1, 2, 0, 0, 0, 0, 0, 0, 1);
`ifdef BRANCH_STATS_EN
    chk("stat_taken3", int'(stat_taken), 3);
    chk("stat_nottaken0", int'(stat_nottaken), 0);
    chk("stat_stalls0", int'(stat_stalls), 0);
`endif
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
